// File: rtl/ising_energy_accumulator.sv
// ising_energy_accumulator: walks J columns, drives the latched spins and accumulates E = sum s_j*h_j.
module ising_energy_accumulator #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int DOT_WIDTH       = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1,
  parameter int ENERGY_WIDTH    = DOT_WIDTH + $clog2(VECTOR_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [VECTOR_SIZE-1:0]         sigma_in,
  output logic [VECTOR_SIZE-1:0]         sigma_out,
  output logic                           col_valid,
  output logic [$clog2(VECTOR_SIZE)-1:0] col_idx,
  input  logic                           col_ready,
  input  logic                           dot_valid,
  input  logic signed [DOT_WIDTH-1:0]    dot_in,
  output logic                           busy,
  output logic                           done,
  output logic signed [ENERGY_WIDTH-1:0] energy_out
);
  localparam int IW = $clog2(VECTOR_SIZE);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e                   state_q;
  logic [VECTOR_SIZE-1:0]   sigma_q;
  logic [IW-1:0]            col_idx_q;
  logic                     col_valid_q, busy_q, done_q;
  logic signed [ENERGY_WIDTH-1:0] acc_q, acc_d, dot_ext, energy_q;
  assign dot_ext = {{(ENERGY_WIDTH-DOT_WIDTH){dot_in[DOT_WIDTH-1]}}, dot_in};
  assign acc_d = sigma_q[col_idx_q] ? acc_q + dot_ext : acc_q - dot_ext;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sigma_q     <= '0;
      col_idx_q   <= '0;
      col_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
      energy_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sigma_q     <= sigma_in;
          acc_q       <= '0;
          col_idx_q   <= '0;
          busy_q      <= 1'b1;
          col_valid_q <= 1'b1;
          state_q     <= REQ;
        end
        REQ: if (col_ready) begin
          col_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (dot_valid) begin
          acc_q <= acc_d;
          if (col_idx_q == IW'(VECTOR_SIZE-1)) state_q <= DONE;
          else begin
            col_idx_q   <= col_idx_q + 1'b1;
            col_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        DONE: begin
          energy_q <= acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sigma_out  = sigma_q;
  assign col_valid  = col_valid_q;
  assign col_idx    = col_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign energy_out = energy_q;
endmodule
